// File: rtl/data_sram_arbiter.sv
// rtl/data_sram_arbiter.sv - two-master arbiter for the single-port data SRAM
// Grants one access per cycle; the response returns to the granted master one cycle later.
module data_sram_arbiter #(
   parameter int ARB_MODE   = 0,
   parameter int STARVE_MAX = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        m0_req,
   input  logic [3:0]  m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_addr_ok,
   output logic        m0_data_ok,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic [3:0]  m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_addr_ok,
   output logic        m1_data_ok,
   output logic [31:0] m1_rdata,
   output logic        data_sram_en,
   output logic [3:0]  data_sram_we,
   output logic [31:0] data_sram_addr,
   output logic [31:0] data_sram_wdata,
   input  logic [31:0] data_sram_rdata
);

   localparam logic [7:0] LP_STARVE_MAX = 8'(STARVE_MAX);

   logic       r_last_gnt;
   logic [7:0] r_starve_cnt;
   logic       r_resp_valid;
   logic       r_resp_id;

   logic       w_pick1;
   logic       w_gnt0;
   logic       w_gnt1;
   logic       w_gnt_any;

   // w_pick1 decides only conflicts; a lone requester always wins.
   always_comb begin
      w_pick1 = 1'b0;
      if (ARB_MODE == 0) begin
         w_pick1 = ~r_last_gnt;
      end else begin
         w_pick1 = (r_starve_cnt == LP_STARVE_MAX);
      end
   end

   assign w_gnt0    = resetn & m0_req & ~(m1_req &  w_pick1);
   assign w_gnt1    = resetn & m1_req & ~(m0_req & ~w_pick1);
   assign w_gnt_any = w_gnt0 | w_gnt1;

   assign m0_addr_ok = w_gnt0;
   assign m1_addr_ok = w_gnt1;

   assign data_sram_en    = w_gnt_any;
   assign data_sram_we    = w_gnt1 ? m1_we : (w_gnt0 ? m0_we : 4'b0000);
   assign data_sram_addr  = w_gnt1 ? m1_addr  : m0_addr;
   assign data_sram_wdata = w_gnt1 ? m1_wdata : m0_wdata;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_last_gnt <= 1'b1;
      end else if (w_gnt0) begin
         r_last_gnt <= 1'b0;
      end else if (w_gnt1) begin
         r_last_gnt <= 1'b1;
      end
   end

   // Saturating count of consecutive cycles master 1 waited with a live request.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_starve_cnt <= 8'd0;
      end else if (w_gnt1 || !m1_req) begin
         r_starve_cnt <= 8'd0;
      end else if (r_starve_cnt != LP_STARVE_MAX) begin
         r_starve_cnt <= r_starve_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_resp_valid <= 1'b0;
         r_resp_id    <= 1'b0;
      end else begin
         r_resp_valid <= w_gnt_any;
         r_resp_id    <= w_gnt1;
      end
   end

   assign m0_data_ok = r_resp_valid & ~r_resp_id;
   assign m1_data_ok = r_resp_valid &  r_resp_id;
   assign m0_rdata   = m0_data_ok ? data_sram_rdata : 32'd0;
   assign m1_rdata   = m1_data_ok ? data_sram_rdata : 32'd0;

endmodule

// File: tb/tb_data_sram_arbiter.sv
// tb/tb_data_sram_arbiter.sv - directed bench for data_sram_arbiter in both arbitration modes
// A round-robin and a fixed-priority instance share stimulus and are checked against a behavioural model.
module tb_data_sram_arbiter;

   localparam int STARVE_FP = 3;

   logic        clk;
   logic        resetn;
   logic        m0_req, m1_req;
   logic [3:0]  m0_we, m1_we;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;

   logic        rr_a0, rr_a1, rr_d0, rr_d1, rr_en;
   logic [3:0]  rr_we;
   logic [31:0] rr_rd0, rr_rd1, rr_addr, rr_wdata, rr_srd;
   logic        fp_a0, fp_a1, fp_d0, fp_d1, fp_en;
   logic [3:0]  fp_we;
   logic [31:0] fp_rd0, fp_rd1, fp_addr, fp_wdata, fp_srd;

   int total = 0;
   int bad   = 0;

   logic [31:0] smem [2][4096];
   logic [31:0] gmem [2][4096];
   int          last_g [2];
   int          denied [2];
   logic        pv [2];
   int          pid [2];
   logic [31:0] pdat [2];

   data_sram_arbiter #(.ARB_MODE(0), .STARVE_MAX(8)) dut_rr (
      .clk(clk), .resetn(resetn),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_addr_ok(rr_a0), .m0_data_ok(rr_d0), .m0_rdata(rr_rd0),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_addr_ok(rr_a1), .m1_data_ok(rr_d1), .m1_rdata(rr_rd1),
      .data_sram_en(rr_en), .data_sram_we(rr_we), .data_sram_addr(rr_addr),
      .data_sram_wdata(rr_wdata), .data_sram_rdata(rr_srd)
   );

   data_sram_arbiter #(.ARB_MODE(1), .STARVE_MAX(STARVE_FP)) dut_fp (
      .clk(clk), .resetn(resetn),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_addr_ok(fp_a0), .m0_data_ok(fp_d0), .m0_rdata(fp_rd0),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_addr_ok(fp_a1), .m1_data_ok(fp_d1), .m1_rdata(fp_rd1),
      .data_sram_en(fp_en), .data_sram_we(fp_we), .data_sram_addr(fp_addr),
      .data_sram_wdata(fp_wdata), .data_sram_rdata(fp_srd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM models: read data appears the cycle after an enabled read; writes return 0.
   always @(posedge clk) begin
      if (rr_en) begin
         if (rr_we != 4'd0) begin
            for (int b = 0; b < 4; b++)
               if (rr_we[b]) smem[0][rr_addr[13:2]][b*8 +: 8] = rr_wdata[b*8 +: 8];
            rr_srd <= 32'd0;
         end else begin
            rr_srd <= smem[0][rr_addr[13:2]];
         end
      end
      if (fp_en) begin
         if (fp_we != 4'd0) begin
            for (int b = 0; b < 4; b++)
               if (fp_we[b]) smem[1][fp_addr[13:2]][b*8 +: 8] = fp_wdata[b*8 +: 8];
            fp_srd <= 32'd0;
         end else begin
            fp_srd <= smem[1][fp_addr[13:2]];
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         pv[k]     = 1'b0;
         pid[k]    = 0;
         last_g[k] = 1;
         denied[k] = 0;
         pdat[k]   = 32'd0;
      end
   endtask

   // Model k: 0 = round-robin, 1 = fixed priority. Checks this cycle, then advances.
   task automatic model_cmp(input int k, input logic a0, input logic a1, input logic en,
                            input logic [3:0] we, input logic [31:0] ad, input logic [31:0] wd,
                            input logic d0, input logic d1,
                            input logic [31:0] rd0, input logic [31:0] rd1);
      string       nm;
      int          g;
      logic        e_d0, e_d1;
      logic [3:0]  e_we;
      logic [31:0] e_ad, e_wd;
      int          idx;
      nm   = (k == 0) ? "rr" : "fp";
      e_d0 = pv[k] && (pid[k] == 0);
      e_d1 = pv[k] && (pid[k] == 1);
      chk({nm, ".data_ok0"}, 32'(d0), 32'(e_d0));
      chk({nm, ".data_ok1"}, 32'(d1), 32'(e_d1));
      chk({nm, ".rdata0"}, rd0, e_d0 ? pdat[k] : 32'd0);
      chk({nm, ".rdata1"}, rd1, e_d1 ? pdat[k] : 32'd0);
      g = -1;
      if (resetn) begin
         if (m0_req && m1_req) begin
            if (k == 0) g = 1 - last_g[k];
            else        g = (denied[k] >= STARVE_FP) ? 1 : 0;
         end else if (m0_req) g = 0;
         else if (m1_req)     g = 1;
      end
      e_we = (g == 0) ? m0_we : ((g == 1) ? m1_we : 4'd0);
      e_ad = (g == 1) ? m1_addr  : m0_addr;
      e_wd = (g == 1) ? m1_wdata : m0_wdata;
      chk({nm, ".addr_ok0"}, 32'(a0), 32'(g == 0));
      chk({nm, ".addr_ok1"}, 32'(a1), 32'(g == 1));
      chk({nm, ".sram_en"}, 32'(en), 32'(g >= 0));
      chk({nm, ".sram_we"}, 32'(we), 32'(e_we));
      chk({nm, ".sram_addr"}, ad, e_ad);
      chk({nm, ".sram_wdata"}, wd, e_wd);
      if (!resetn) begin
         pv[k] = 1'b0; pid[k] = 0; last_g[k] = 1; denied[k] = 0;
      end else begin
         if (m1_req && g != 1) denied[k] = (denied[k] + 1 > STARVE_FP) ? STARVE_FP : denied[k] + 1;
         else                  denied[k] = 0;
         if (g >= 0) begin
            last_g[k] = g;
            pv[k]     = 1'b1;
            pid[k]    = g;
            idx       = int'(e_ad[13:2]);
            if (e_we == 4'd0) begin
               pdat[k] = gmem[k][idx];
            end else begin
               pdat[k] = 32'd0;
               for (int b = 0; b < 4; b++)
                  if (e_we[b]) gmem[k][idx][b*8 +: 8] = e_wd[b*8 +: 8];
            end
         end else begin
            pv[k] = 1'b0;
         end
      end
   endtask

   always @(negedge resetn) model_reset();

   always @(negedge clk) begin
      model_cmp(0, rr_a0, rr_a1, rr_en, rr_we, rr_addr, rr_wdata, rr_d0, rr_d1, rr_rd0, rr_rd1);
      model_cmp(1, fp_a0, fp_a1, fp_en, fp_we, fp_addr, fp_wdata, fp_d0, fp_d1, fp_rd0, fp_rd1);
   end

   task automatic drive(input logic r0, input logic [3:0] w0, input logic [31:0] ad0, input logic [31:0] wd0,
                        input logic r1, input logic [3:0] w1, input logic [31:0] ad1, input logic [31:0] wd1);
      m0_req = r0; m0_we = w0; m0_addr = ad0; m0_wdata = wd0;
      m1_req = r1; m1_we = w1; m1_addr = ad1; m1_wdata = wd1;
   endtask

   logic [7:0] rr_pat;
   logic [7:0] fp_pat;

   initial begin
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 4096; i++) begin
            smem[k][i] = 32'd0;
            gmem[k][i] = 32'd0;
         end
         smem[k][12'h400] = 32'hDEADBEEF;
         gmem[k][12'h400] = 32'hDEADBEEF;
         smem[k][12'h401] = 32'hCAFEF00D;
         gmem[k][12'h401] = 32'hCAFEF00D;
      end
      rr_srd = 32'd0;
      fp_srd = 32'd0;
      model_reset();
      rr_pat = 8'b1010_1010;
      fp_pat = 8'b1000_1000;
      resetn = 1'b0;
      drive(1'b1, 4'd0, 32'h1000, 32'd0, 1'b1, 4'd0, 32'h1004, 32'd0);

      repeat (3) begin
         @(negedge clk);
         chk("rst.rr_addr_ok0", 32'(rr_a0), 32'd0);
         chk("rst.fp_addr_ok1", 32'(fp_a1), 32'd0);
         chk("rst.rr_sram_en", 32'(rr_en), 32'd0);
      end

      @(posedge clk); #1;
      resetn = 1'b1;
      drive(1'b1, 4'd0, 32'h1000, 32'd0, 1'b0, 4'd0, 32'h0, 32'd0);
      @(negedge clk);
      chk("first.rr_addr_ok0", 32'(rr_a0), 32'd1);
      chk("first.fp_addr_ok0", 32'(fp_a0), 32'd1);

      @(posedge clk); #1;
      drive(1'b0, 4'd0, 32'h1000, 32'd0, 1'b1, 4'b0011, 32'h20, 32'h12345678);
      @(negedge clk);
      chk("first.rr_data_ok0", 32'(rr_d0), 32'd1);
      chk("first.rr_rdata0", rr_rd0, 32'hDEADBEEF);
      chk("first.rr_data_ok1", 32'(rr_d1), 32'd0);
      chk("wr.rr_sram_we", 32'(rr_we), 32'h3);
      chk("wr.rr_sram_wdata", rr_wdata, 32'h12345678);

      @(posedge clk); #1;
      drive(1'b1, 4'd0, 32'h20, 32'd0, 1'b1, 4'd0, 32'h1004, 32'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("rr.grant_seq", 32'(rr_a1), 32'(rr_pat[i]));
         chk("fp.grant_seq", 32'(fp_a1), 32'(fp_pat[i]));
         if (i == 0) chk("wr.rr_data_ok1", 32'(rr_d1), 32'd1);
         if (i == 1) chk("rd20.rr_rdata0", rr_rd0, 32'h00005678);
         if (i == 2) chk("rr.rdata1", rr_rd1, 32'hCAFEF00D);
         @(posedge clk); #1;
      end

      drive(1'b1, 4'd0, 32'h1000, 32'd0, 1'b0, 4'd0, 32'h1004, 32'd0);
      @(negedge clk);
      chk("midrst.rr_addr_ok0", 32'(rr_a0), 32'd1);
      #2;
      resetn = 1'b0;
      drive(1'b0, 4'd0, 32'h1000, 32'd0, 1'b0, 4'd0, 32'h1004, 32'd0);
      repeat (2) begin
         @(negedge clk);
         chk("midrst.rr_data_ok0", 32'(rr_d0), 32'd0);
         chk("midrst.fp_data_ok0", 32'(fp_d0), 32'd0);
      end
      @(posedge clk); #1;
      resetn = 1'b1;
      drive(1'b1, 4'd0, 32'h1000, 32'd0, 1'b1, 4'd0, 32'h1004, 32'd0);
      @(negedge clk);
      chk("postrst.rr_addr_ok0", 32'(rr_a0), 32'd1);
      chk("postrst.fp_addr_ok0", 32'(fp_a0), 32'd1);
      chk("postrst.rr_data_ok0", 32'(rr_d0), 32'd0);

      @(posedge clk); #1;
      drive(1'b0, 4'd0, 32'h1000, 32'd0, 1'b0, 4'd0, 32'h1004, 32'd0);
      repeat (10) begin
         @(negedge clk);
         chk("idle.rr_sram_en", 32'(rr_en), 32'd0);
         chk("idle.fp_sram_we", 32'(fp_we), 32'd0);
      end

      @(posedge clk); #1;
      drive(1'b1, 4'd0, 32'h1000, 32'd0, 1'b1, 4'd0, 32'h1004, 32'd0);
      @(negedge clk);
      chk("afteridle.rr_addr_ok1", 32'(rr_a1), 32'd1);
      chk("afteridle.fp_addr_ok0", 32'(fp_a0), 32'd1);

      @(posedge clk); #1;
      drive(1'b0, 4'd0, 32'h0, 32'd0, 1'b0, 4'd0, 32'h0, 32'd0);
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
